halt_ctrl: RTL and testbench



---
 rtl/halt_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_halt_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/halt_ctrl.sv
// -----------------------------------------------------------------------------
// halt_ctrl
//
// Trap and halt sequencer for the simulated RV64 single-issue core. It watches
// the commit stream for ebreak, the all-zero illegal word, or a commit-watchdog
// expiry. When one of these happens it freezes the core, waits for outstanding
// memory traffic to drain, and then offers a halt record to the harness over a
// valid/ack handshake. Free-running cycle and retired-instruction counters are
// also exported.
//
// Ports
//   clock         core clock, all state updates on the rising edge
//   reset         synchronous, active-low
//   commit_valid  an instruction retires this cycle
//   commit_inst   retiring instruction word
//   commit_pc     pc of the retiring instruction
//   a0            architectural x10, valid with commit_valid
//   mem_busy      store or bus transaction outstanding
//   stall_req     freeze fetch and commit
//   halt_valid    halt record valid
//   halt_ack      harness accepts the record
//   halt_code     0 GOOD, 1 BAD, 2 TIMEOUT, 3 ILLEGAL
//   halt_pc       pc of the halting instruction, last committed pc on TIMEOUT
//   halt_a0       a0 captured at the halt event
//   cycle_cnt     cycles since reset (frozen once DONE)
//   instret_cnt   instructions retired since reset
//   done          sticky, the halt record has been accepted
//
// State table
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_RUN    | core running, commits counted, watchdog armed
//   ST_DRAIN  | core frozen, waiting for drain timer and mem_busy to clear
//   ST_REPORT | halt record presented, waiting for halt_ack
//   ST_DONE   | record accepted, everything held until reset
// -----------------------------------------------------------------------------
module halt_ctrl #(
    parameter int XLEN         = 64,
    parameter int DRAIN_CYCLES = 4,
    parameter int WDT_LIMIT    = 100000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [31:0]     commit_inst,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] a0,
    input  logic            mem_busy,
    output logic            stall_req,
    output logic            halt_valid,
    input  logic            halt_ack,
    output logic [1:0]      halt_code,
    output logic [XLEN-1:0] halt_pc,
    output logic [XLEN-1:0] halt_a0,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt,
    output logic            done
);

    localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
    localparam logic [31:0] INST_ILLEGAL = 32'h0000_0000;

    localparam logic [1:0] CODE_GOOD    = 2'd0;
    localparam logic [1:0] CODE_BAD     = 2'd1;
    localparam logic [1:0] CODE_TIMEOUT = 2'd2;
    localparam logic [1:0] CODE_ILLEGAL = 2'd3;

    localparam int WDT_W = (WDT_LIMIT < 2) ? 1 : $clog2(WDT_LIMIT);
    localparam int DRN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    // The watchdog expires on the idle cycle that takes it to WDT_LIMIT-1, so
    // the trip point is the registered value one below that.
    localparam logic [WDT_W-1:0] WDT_TRIP = WDT_W'(WDT_LIMIT - 2);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [63:0]       cycle_nxt;
    logic [63:0]       instret_nxt;
    logic [XLEN-1:0]   last_pc;
    logic [XLEN-1:0]   last_pc_nxt;
    logic [WDT_W-1:0]  wdt;
    logic [WDT_W-1:0]  wdt_nxt;
    logic [DRN_W-1:0]  drain_cnt;
    logic [DRN_W-1:0]  drain_nxt;
    logic [1:0]        code_nxt;
    logic [XLEN-1:0]   hpc_nxt;
    logic [XLEN-1:0]   ha0_nxt;

    // Outputs that depend only on the registered state.
    assign stall_req  = (state != ST_RUN);
    assign halt_valid = (state == ST_REPORT);
    assign done       = (state == ST_DONE);

    always_comb begin
        state_nxt   = state;
        cycle_nxt   = cycle_cnt;
        instret_nxt = instret_cnt;
        last_pc_nxt = last_pc;
        wdt_nxt     = wdt;
        drain_nxt   = drain_cnt;
        code_nxt    = halt_code;
        hpc_nxt     = halt_pc;
        ha0_nxt     = halt_a0;

        case (state)
            ST_RUN: begin
                cycle_nxt = cycle_cnt + 64'd1;
                if (commit_valid) begin
                    // A commit always wins over a simultaneous watchdog trip.
                    instret_nxt = instret_cnt + 64'd1;
                    last_pc_nxt = commit_pc;
                    wdt_nxt     = '0;
                    if (commit_inst == INST_EBREAK) begin
                        code_nxt  = (a0 == '0) ? CODE_GOOD : CODE_BAD;
                        hpc_nxt   = commit_pc;
                        ha0_nxt   = a0;
                        drain_nxt = DRN_LOAD;
                        state_nxt = ST_DRAIN;
                    end else if (commit_inst == INST_ILLEGAL) begin
                        code_nxt  = CODE_ILLEGAL;
                        hpc_nxt   = commit_pc;
                        ha0_nxt   = a0;
                        drain_nxt = DRN_LOAD;
                        state_nxt = ST_DRAIN;
                    end
                end else begin
                    wdt_nxt = wdt + WDT_W'(1);
                    if (wdt == WDT_TRIP) begin
                        code_nxt  = CODE_TIMEOUT;
                        hpc_nxt   = last_pc;
                        ha0_nxt   = a0;
                        drain_nxt = DRN_LOAD;
                        state_nxt = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                cycle_nxt = cycle_cnt + 64'd1;
                if ((drain_cnt == '0) && !mem_busy) begin
                    state_nxt = ST_REPORT;
                end else if (drain_cnt != '0) begin
                    drain_nxt = drain_cnt - DRN_W'(1);
                end
            end

            ST_REPORT: begin
                cycle_nxt = cycle_cnt + 64'd1;
                if (halt_ack) begin
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                state_nxt = ST_DONE;
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_RUN;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            last_pc     <= '0;
            wdt         <= '0;
            drain_cnt   <= '0;
            halt_code   <= '0;
            halt_pc     <= '0;
            halt_a0     <= '0;
        end else begin
            state       <= state_nxt;
            cycle_cnt   <= cycle_nxt;
            instret_cnt <= instret_nxt;
            last_pc     <= last_pc_nxt;
            wdt         <= wdt_nxt;
            drain_cnt   <= drain_nxt;
            halt_code   <= code_nxt;
            halt_pc     <= hpc_nxt;
            halt_a0     <= ha0_nxt;
        end
    end

endmodule

// File: tb/tb_halt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_halt_ctrl
//
// Scenario tasks for the halt sequencer plus a randomized commit stream whose
// expected halt event, record and timing are derived by scanning the stimulus
// arrays with the trap rules.
// -----------------------------------------------------------------------------
module tb_halt_ctrl;

    localparam int XLEN  = 64;
    localparam int DRAIN = 4;
    localparam int WDT   = 16;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0015_0513;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            commit_valid = 1'b0;
    logic [31:0]     commit_inst = ADDI;
    logic [XLEN-1:0] commit_pc = '0;
    logic [XLEN-1:0] a0 = '0;
    logic            mem_busy = 1'b0;
    logic            stall_req;
    logic            halt_valid;
    logic            halt_ack = 1'b0;
    logic [1:0]      halt_code;
    logic [XLEN-1:0] halt_pc;
    logic [XLEN-1:0] halt_a0;
    logic [63:0]     cycle_cnt;
    logic [63:0]     instret_cnt;
    logic            done;

    int checks   = 0;
    int failures = 0;

    halt_ctrl #(
        .XLEN         (XLEN),
        .DRAIN_CYCLES (DRAIN),
        .WDT_LIMIT    (WDT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_inst  (commit_inst),
        .commit_pc    (commit_pc),
        .a0           (a0),
        .mem_busy     (mem_busy),
        .stall_req    (stall_req),
        .halt_valid   (halt_valid),
        .halt_ack     (halt_ack),
        .halt_code    (halt_code),
        .halt_pc      (halt_pc),
        .halt_a0      (halt_a0),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt),
        .done         (done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        commit_valid = 1'b0;
        commit_inst  = ADDI;
        commit_pc    = '0;
        a0           = '0;
        mem_busy     = 1'b0;
        halt_ack     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic commit(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] v);
        commit_valid = 1'b1;
        commit_inst  = inst;
        commit_pc    = pc;
        a0           = v;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        checks++;
        if ({stall_req, halt_valid, done, halt_code} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got stall=%0b valid=%0b done=%0b code=%0d exp all 0", stall_req, halt_valid, done, halt_code);
        end
        checks++;
        if (halt_pc !== 64'd0 || halt_a0 !== 64'd0) begin
            failures++;
            $display("FAIL reset_fields got pc=%0h a0=%0h exp 0", halt_pc, halt_a0);
        end
        checks++;
        if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
            failures++;
            $display("FAIL reset_counters got cycle=%0d instret=%0d exp 0", cycle_cnt, instret_cnt);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (cycle_cnt !== 64'd1) begin
            failures++;
            $display("FAIL reset_first_cycle got %0d exp 1", cycle_cnt);
        end
    endtask

    task automatic test_good_trap();
        do_reset();
        halt_ack = 1'b1;
        for (int i = 0; i < 10; i++) commit(ADDI, 64'h8000_0000 + 64'(4 * i), 64'(i + 1));
        commit(EBREAK, 64'h8000_0028, 64'd0);
        checks++;
        if (stall_req !== 1'b1 || halt_valid !== 1'b0 || instret_cnt !== 64'd11) begin
            failures++;
            $display("FAIL good_event got stall=%0b valid=%0b instret=%0d exp 1 0 11", stall_req, halt_valid, instret_cnt);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (halt_valid !== 1'b0) begin
                failures++;
                $display("FAIL good_early_valid edge+%0d got %0b exp 0", k, halt_valid);
            end
        end
        tick();
        checks++;
        if (halt_valid !== 1'b1 || halt_code !== 2'd0 || halt_pc !== 64'h8000_0028 || halt_a0 !== 64'd0) begin
            failures++;
            $display("FAIL good_record got valid=%0b code=%0d pc=%0h a0=%0h exp 1 0 80000028 0", halt_valid, halt_code, halt_pc, halt_a0);
        end
        checks++;
        if (instret_cnt !== 64'd11 || cycle_cnt !== 64'd16) begin
            failures++;
            $display("FAIL good_counts got instret=%0d cycle=%0d exp 11 16", instret_cnt, cycle_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b1 || halt_valid !== 1'b0 || stall_req !== 1'b1 || cycle_cnt !== 64'd17) begin
            failures++;
            $display("FAIL good_done got done=%0b valid=%0b stall=%0b cycle=%0d exp 1 0 1 17", done, halt_valid, stall_req, cycle_cnt);
        end
        repeat (3) tick();
        checks++;
        if (cycle_cnt !== 64'd17 || done !== 1'b1 || halt_pc !== 64'h8000_0028) begin
            failures++;
            $display("FAIL good_frozen got cycle=%0d done=%0b pc=%0h exp 17 1 80000028", cycle_cnt, done, halt_pc);
        end
    endtask

    task automatic test_bad_drain();
        do_reset();
        for (int i = 0; i < 3; i++) commit(ADDI, 64'h8000_0000 + 64'(4 * i), 64'd3);
        commit(EBREAK, 64'h8000_0200, 64'd7);
        mem_busy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            commit_valid = 1'b1;
            commit_inst  = (k == 5) ? EBREAK : ADDI;
            commit_pc    = 64'h9000_0000 + 64'($urandom_range(0, 255));
            a0           = 64'($urandom);
            tick();
            checks++;
            if (halt_valid !== 1'b0 || instret_cnt !== 64'd4 || halt_pc !== 64'h8000_0200) begin
                failures++;
                $display("FAIL bad_drain_hold k=%0d got valid=%0b instret=%0d pc=%0h exp 0 4 80000200", k, halt_valid, instret_cnt, halt_pc);
            end
        end
        commit_valid = 1'b0;
        mem_busy     = 1'b0;
        tick();
        checks++;
        if (halt_valid !== 1'b1 || halt_code !== 2'd1 || halt_a0 !== 64'd7 || halt_pc !== 64'h8000_0200) begin
            failures++;
            $display("FAIL bad_record got valid=%0b code=%0d a0=%0h pc=%0h exp 1 1 7 80000200", halt_valid, halt_code, halt_a0, halt_pc);
        end
        halt_ack = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL bad_done got %0b exp 1", done);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        commit(ADDI, 64'h8000_0100, 64'd5);
        a0 = 64'hABCD;
        for (int k = 1; k <= WDT - 2; k++) begin
            tick();
            checks++;
            if (stall_req !== 1'b0) begin
                failures++;
                $display("FAIL wdt_early idle=%0d got stall=%0b exp 0", k, stall_req);
            end
        end
        tick();
        checks++;
        if (stall_req !== 1'b1) begin
            failures++;
            $display("FAIL wdt_trip got stall=%0b exp 1", stall_req);
        end
        repeat (DRAIN + 1) tick();
        checks++;
        if (halt_valid !== 1'b1 || halt_code !== 2'd2 || halt_pc !== 64'h8000_0100 || halt_a0 !== 64'hABCD) begin
            failures++;
            $display("FAIL wdt_record got valid=%0b code=%0d pc=%0h a0=%0h exp 1 2 80000100 abcd", halt_valid, halt_code, halt_pc, halt_a0);
        end

        do_reset();
        commit(ADDI, 64'h8000_0100, 64'd5);
        repeat (WDT - 2) tick();
        commit(ADDI, 64'h8000_0104, 64'd6);
        checks++;
        if (stall_req !== 1'b0 || instret_cnt !== 64'd2) begin
            failures++;
            $display("FAIL wdt_commit_wins got stall=%0b instret=%0d exp 0 2", stall_req, instret_cnt);
        end
        repeat (WDT - 2) tick();
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL wdt_cleared got stall=%0b exp 0", stall_req);
        end
        tick();
        repeat (DRAIN + 1) tick();
        checks++;
        if (halt_valid !== 1'b1 || halt_code !== 2'd2 || halt_pc !== 64'h8000_0104) begin
            failures++;
            $display("FAIL wdt_second got valid=%0b code=%0d pc=%0h exp 1 2 80000104", halt_valid, halt_code, halt_pc);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        commit(ADDI, 64'h8000_0000, 64'd1);
        commit(32'h0, 64'h8000_0004, 64'd9);
        repeat (DRAIN + 1) tick();
        checks++;
        if (halt_valid !== 1'b1 || halt_code !== 2'd3 || halt_pc !== 64'h8000_0004 || halt_a0 !== 64'd9 || instret_cnt !== 64'd2) begin
            failures++;
            $display("FAIL illegal_record got valid=%0b code=%0d pc=%0h a0=%0h instret=%0d exp 1 3 80000004 9 2", halt_valid, halt_code, halt_pc, halt_a0, instret_cnt);
        end
    endtask

    task automatic test_handshake_hold();
        do_reset();
        commit(EBREAK, 64'h8000_0300, 64'd0);
        repeat (DRAIN + 1) tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (halt_valid !== 1'b1 || halt_code !== 2'd0 || halt_pc !== 64'h8000_0300 || cycle_cnt !== 64'(6 + k)) begin
                failures++;
                $display("FAIL hold k=%0d got valid=%0b code=%0d pc=%0h cycle=%0d exp 1 0 80000300 %0d", k, halt_valid, halt_code, halt_pc, cycle_cnt, 6 + k);
            end
        end
        halt_ack = 1'b1;
        tick();
        halt_ack = 1'b0;
        repeat (5) tick();
        checks++;
        if (done !== 1'b1 || halt_valid !== 1'b0 || cycle_cnt !== 64'd27 || halt_pc !== 64'h8000_0300) begin
            failures++;
            $display("FAIL hold_done got done=%0b valid=%0b cycle=%0d pc=%0h exp 1 0 27 80000300", done, halt_valid, cycle_cnt, halt_pc);
        end
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            commit(ADDI, 64'h8000_0000, 64'd1);
            commit(EBREAK, 64'h8000_0004, 64'd2);
            mem_busy = (pass == 0);
            repeat ((pass == 0) ? 3 : DRAIN + 1) tick();
            checks++;
            if (stall_req !== 1'b1 || halt_valid !== (pass == 1)) begin
                failures++;
                $display("FAIL mid_setup pass=%0d got stall=%0b valid=%0b", pass, stall_req, halt_valid);
            end
            reset = 1'b0;
            tick();
            checks++;
            if ({stall_req, halt_valid, done, halt_code} !== 5'b0 || halt_pc !== 64'd0 || halt_a0 !== 64'd0 ||
                cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
                failures++;
                $display("FAIL mid_reset pass=%0d got stall=%0b valid=%0b pc=%0h cycle=%0d instret=%0d exp all 0", pass, stall_req, halt_valid, halt_pc, cycle_cnt, instret_cnt);
            end
            reset    = 1'b1;
            mem_busy = 1'b0;
            for (int i = 0; i < 3; i++) commit(ADDI, 64'h8000_0000 + 64'(4 * i), 64'd1);
            checks++;
            if (instret_cnt !== 64'd3 || cycle_cnt !== 64'd3 || stall_req !== 1'b0) begin
                failures++;
                $display("FAIL mid_restart pass=%0d got instret=%0d cycle=%0d stall=%0b exp 3 3 0", pass, instret_cnt, cycle_cnt, stall_req);
            end
        end
    endtask

    task automatic test_random();
        logic        cv   [200];
        logic [31:0] ci   [200];
        logic [63:0] cpc  [200];
        logic [63:0] ca0  [200];
        logic        busy [200];
        logic [63:0] ins_at [200];
        int          h, rep, idle, r, n, dly;
        logic [1:0]  m_code;
        logic [63:0] m_pc, m_a0, lpc;

        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 200; i++) begin
                r       = int'($urandom_range(0, 99));
                cv[i]   = (i <= 60) && ($urandom_range(0, 99) < 55);
                ci[i]   = (r < 3) ? EBREAK : (r < 5) ? 32'h0 : ADDI;
                cpc[i]  = 64'h8000_0000 + 64'(4 * i);
                ca0[i]  = ($urandom_range(0, 1) == 1) ? 64'd0 : {$urandom, $urandom};
                busy[i] = (i < 190) && ($urandom_range(0, 99) < 40);
            end

            // Reference: scan the stream for the first halting event.
            n = 0; idle = 0; lpc = '0; h = 0; m_code = 0; m_pc = '0; m_a0 = '0;
            for (int i = 1; i < 200; i++) begin
                if (h == 0) begin
                    if (cv[i]) begin
                        n++;
                        lpc  = cpc[i];
                        idle = 0;
                        if (ci[i] == EBREAK) begin
                            h = i; m_code = (ca0[i] == 0) ? 2'd0 : 2'd1; m_pc = cpc[i]; m_a0 = ca0[i];
                        end else if (ci[i] == 32'h0) begin
                            h = i; m_code = 2'd3; m_pc = cpc[i]; m_a0 = ca0[i];
                        end
                    end else begin
                        idle++;
                        if (idle == WDT - 1) begin
                            h = i; m_code = 2'd2; m_pc = lpc; m_a0 = ca0[i];
                        end
                    end
                end
                ins_at[i] = 64'(n);
            end
            rep = h + DRAIN + 1;
            while (busy[rep]) rep++;

            do_reset();
            for (int e = 1; e <= rep; e++) begin
                commit_valid = cv[e];
                commit_inst  = ci[e];
                commit_pc    = cpc[e];
                a0           = ca0[e];
                mem_busy     = busy[e];
                tick();
                checks++;
                if (e < h) begin
                    if (stall_req !== 1'b0 || instret_cnt !== ins_at[e]) begin
                        failures++;
                        $display("FAIL rand_run it=%0d e=%0d got stall=%0b instret=%0d exp 0 %0d", it, e, stall_req, instret_cnt, ins_at[e]);
                    end
                end else if (e < rep) begin
                    if (stall_req !== 1'b1 || halt_valid !== 1'b0 || instret_cnt !== ins_at[h]) begin
                        failures++;
                        $display("FAIL rand_drain it=%0d e=%0d got stall=%0b valid=%0b instret=%0d exp 1 0 %0d", it, e, stall_req, halt_valid, instret_cnt, ins_at[h]);
                    end
                end else begin
                    if (halt_valid !== 1'b1 || halt_code !== m_code || halt_pc !== m_pc || halt_a0 !== m_a0 ||
                        cycle_cnt !== 64'(e) || instret_cnt !== ins_at[h]) begin
                        failures++;
                        $display("FAIL rand_record it=%0d got valid=%0b code=%0d pc=%0h a0=%0h cycle=%0d exp 1 %0d %0h %0h %0d",
                                 it, halt_valid, halt_code, halt_pc, halt_a0, cycle_cnt, m_code, m_pc, m_a0, e);
                    end
                end
            end
            idle_inputs();
            dly = int'($urandom_range(0, 3));
            repeat (dly) tick();
            halt_ack = 1'b1;
            tick();
            halt_ack = 1'b0;
            tick();
            checks++;
            if (done !== 1'b1 || halt_valid !== 1'b0 || cycle_cnt !== 64'(rep + dly + 1)) begin
                failures++;
                $display("FAIL rand_done it=%0d got done=%0b valid=%0b cycle=%0d exp 1 0 %0d", it, done, halt_valid, cycle_cnt, rep + dly + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_trap();
        test_bad_drain();
        test_watchdog();
        test_illegal();
        test_handshake_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL global_timeout got time=%0t exp finish earlier", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
